// File: rtl/if_id_buf_if.sv
// ---------------------------------------------------------------------------
// if_id_buf_if
//   Bundles the fetch-side and decode-side buses of the IF/ID skid stage.
//
//   Fetch side  : if_instr, if_pc_add2, if_valid, if_err (into the stage),
//                 if_ready (out of the stage, PC write enable).
//   Decode side : instr_out, pc_add2_out, valid_out, err_out (out of stage).
//
//   modport master : the environment (fetch unit + decode consumer).
//   modport slave  : the if_id_buf stage itself.
// ---------------------------------------------------------------------------
interface if_id_buf_if;
  logic [15:0] if_instr;
  logic [15:0] if_pc_add2;
  logic        if_valid;
  logic        if_err;
  logic        if_ready;

  logic [15:0] instr_out;
  logic [15:0] pc_add2_out;
  logic        valid_out;
  logic        err_out;

  modport master (
    output if_instr,
    output if_pc_add2,
    output if_valid,
    output if_err,
    input  if_ready,
    input  instr_out,
    input  pc_add2_out,
    input  valid_out,
    input  err_out
  );

  modport slave (
    input  if_instr,
    input  if_pc_add2,
    input  if_valid,
    input  if_err,
    output if_ready,
    output instr_out,
    output pc_add2_out,
    output valid_out,
    output err_out
  );
endinterface

// File: rtl/if_id_buf.sv
// ---------------------------------------------------------------------------
// if_id_buf
//   IF/ID pipeline stage with a one-entry skid buffer, directly upstream of
//   the ID/EX register. Holds fetched instructions across load-use and
//   data-memory stalls, squashes wrong-path fetches after a taken branch or
//   jump, presents an instruction or a NOP to decode, and latches a sticky
//   flag once a HALT leaves decode.
//
//   Ports
//     clk         : clock
//     rst_n       : asynchronous active-low reset
//     bus         : if_id_buf_if.slave (fetch in / decode out / if_ready)
//     id_stall    : load-use stall, decode must hold
//     dmem_stall  : data-memory stall, decode must hold
//     flush       : taken branch/jump resolved in EX
//     halt_seen   : sticky, a HALT has left decode
//
//   Optional statistics (macro IF_ID_STATS_EN):
//     stall_cycles, flush_count, drop_count : saturating 16-bit counters.
//     Without the macro these ports and counters do not exist.
//
//   Parameters
//     DROP_CNT  : in-flight fetch beats discarded after a flush (0..3)
//     NOP_INSTR : instruction shown to decode while the stage is empty
// ---------------------------------------------------------------------------
//   state | meaning
//   ------+-------------------------------------------------------------
//   EMPTY | no instruction held; decode sees NOP_INSTR
//   FULL  | main entry holds the instruction presented to decode
//   SKID  | main presented, skid holds the beat accepted during a hold
// ---------------------------------------------------------------------------
module if_id_buf #(
  parameter logic [1:0]  DROP_CNT  = 2'd1,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic          clk,
  input  logic          rst_n,
  if_id_buf_if.slave    bus,
  input  logic          id_stall,
  input  logic          dmem_stall,
  input  logic          flush,
  output logic          halt_seen
`ifdef IF_ID_STATS_EN
  ,
  output logic [15:0]   stall_cycles,
  output logic [15:0]   flush_count,
  output logic [15:0]   drop_count
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t      state;

  logic [15:0] mainInstr;
  logic [15:0] mainPc;
  logic        mainErr;
  logic [15:0] skidInstr;
  logic [15:0] skidPc;
  logic        skidErr;

  logic [1:0]  dropCnt;
  logic        haltSeen;

  logic        hold;
  logic        accept;
  logic        dropBeat;
  logic        haltLeaving;
  logic        validOut;

  always_comb begin
    hold        = id_stall | dmem_stall;
    accept      = bus.if_valid & (dropCnt == 2'd0) & ~haltSeen;
    // A beat landing in the flush cycle is discarded by the flush itself;
    // the counter is reloaded there instead of decremented.
    dropBeat    = bus.if_valid & (dropCnt != 2'd0) & ~flush;
    validOut    = (state != EMPTY);
    // HALT opcode is 5'b00000 in the top bits; it counts only when decode
    // actually consumes it.
    haltLeaving = validOut & (mainInstr[15:11] == 5'b00000) & ~hold & ~flush;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      mainInstr <= NOP_INSTR;
      mainPc    <= 16'h0000;
      mainErr   <= 1'b0;
      skidInstr <= NOP_INSTR;
      skidPc    <= 16'h0000;
      skidErr   <= 1'b0;
      dropCnt   <= 2'd0;
      haltSeen  <= 1'b0;
    end else if (flush) begin
      // Entries are invalidated through the state; main data is kept so
      // pc_add2_out keeps showing the last loaded PC.
      state   <= EMPTY;
      dropCnt <= DROP_CNT;
    end else begin
      if (dropBeat)
        dropCnt <= dropCnt - 2'd1;
      if (haltLeaving)
        haltSeen <= 1'b1;

      unique case (state)
        EMPTY: begin
          if (accept) begin
            mainInstr <= bus.if_instr;
            mainPc    <= bus.if_pc_add2;
            mainErr   <= bus.if_err;
            state     <= FULL;
          end
        end

        FULL: begin
          if (!hold) begin
            if (accept) begin
              mainInstr <= bus.if_instr;
              mainPc    <= bus.if_pc_add2;
              mainErr   <= bus.if_err;
            end else begin
              state <= EMPTY;
            end
          end else if (accept) begin
            // Decode is frozen but fetch already launched this beat.
            skidInstr <= bus.if_instr;
            skidPc    <= bus.if_pc_add2;
            skidErr   <= bus.if_err;
            state     <= SKID;
          end
        end

        SKID: begin
          // if_ready is low here, so fetch is not advancing; promote skid.
          if (!hold) begin
            mainInstr <= skidInstr;
            mainPc    <= skidPc;
            mainErr   <= skidErr;
            state     <= FULL;
          end
        end

        default: state <= EMPTY;
      endcase
    end
  end

  assign bus.valid_out   = validOut;
  assign bus.instr_out   = validOut ? mainInstr : NOP_INSTR;
  assign bus.pc_add2_out = mainPc;
  assign bus.err_out     = validOut & mainErr;
  // flush is the only combinational term: a redirect must stop the PC
  // from latching the wrong-path increment in the same cycle.
  assign bus.if_ready    = (state != SKID) & ~haltSeen & ~flush;
  assign halt_seen       = haltSeen;

`ifdef IF_ID_STATS_EN
  logic [15:0] stallCnt;
  logic [15:0] flushCnt;
  logic [15:0] dropStatCnt;
  logic        statDrop;

  always_comb begin
    statDrop = bus.if_valid & (flush | (dropCnt != 2'd0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCnt    <= 16'h0000;
      flushCnt    <= 16'h0000;
      dropStatCnt <= 16'h0000;
    end else begin
      if (hold && validOut && (stallCnt != 16'hFFFF))
        stallCnt <= stallCnt + 16'h0001;
      if (flush && (flushCnt != 16'hFFFF))
        flushCnt <= flushCnt + 16'h0001;
      if (statDrop && (dropStatCnt != 16'hFFFF))
        dropStatCnt <= dropStatCnt + 16'h0001;
    end
  end

  assign stall_cycles = stallCnt;
  assign flush_count  = flushCnt;
  assign drop_count   = dropStatCnt;
`endif

endmodule

// File: doc/if_id_buf.md
Name: if_id_buf

Overview:
- IF/ID pipeline stage with a one-entry skid buffer; sits directly upstream of the ID/EX register.
- Accepts fetched instructions from instruction memory, holds them across load-use and data-memory stalls, and squashes wrong-path fetches after a taken branch or jump.
- Presents a valid instruction, or a NOP, to decode.
- Detects HALT in decode and stops further fetch acceptance.

Parameters:
- DROP_CNT, 1: number of in-flight if_valid beats discarded after a flush (range 0..3, held in a 2-bit counter).
- NOP_INSTR, 16'h0800: instruction driven on instr_out when the stage is empty or flushed.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- if_instr  in  16  instruction from instruction memory.
- if_pc_add2  in  16  PC+2 of if_instr.
- if_valid  in  1  if_instr/if_pc_add2/if_err are valid this cycle.
- if_err  in  1  fetch error (misaligned or memory error).
- id_stall  in  1  load-use stall from the hazard unit; ID must hold.
- dmem_stall  in  1  global data-memory stall; ID must hold.
- flush  in  1  taken branch or jump resolved in EX.
- instr_out  out  16  instruction to decode.
- pc_add2_out  out  16  PC+2 to decode.
- valid_out  out  1  instr_out is a real instruction.
- err_out  out  1  error tagged on the current instruction.
- if_ready  out  1  stage can accept a fetch next edge; drives the PC write enable.
- halt_seen  out  1  sticky flag: a HALT has left decode.

Behaviour:
- hold = id_stall | dmem_stall. Storage: main entry {instr, pc_add2, err} and skid entry {instr, pc_add2, err}. State is one of EMPTY, FULL, SKID.
- Reset (asynchronous, rst_n=0):
  - state=EMPTY, drop counter=0, halt_seen=0.
  - instr_out=NOP_INSTR, pc_add2_out=0, valid_out=0, err_out=0, if_ready=1.
- accept = if_valid & (drop counter==0) & ~halt_seen.
- State transitions. flush has highest priority and applies even when hold=1.
  - EMPTY: accept -> load main, go to FULL; otherwise stay in EMPTY.
  - FULL, hold=0: accept -> load main, stay in FULL; no accept -> go to EMPTY.
  - FULL, hold=1: accept -> load skid, go to SKID; no accept -> stay, main is unchanged.
  - SKID, hold=0: main<=skid, go to FULL. if_valid is not accepted this cycle.
  - SKID, hold=1: stay; both entries are unchanged.
  - flush=1 (any state): next state is EMPTY, both entries are invalidated, drop counter<=DROP_CNT. An if_valid beat arriving in the flush cycle is discarded.
- Drop counter: decrements by 1 on every if_valid beat while the counter is nonzero; those beats are discarded. A flush while the counter is nonzero reloads it to DROP_CNT.
- Outputs, all registered or derived from registered state:
  - valid_out = (state != EMPTY).
  - instr_out = valid_out ? main.instr : NOP_INSTR.
  - pc_add2_out = main.pc_add2, also when invalid.
  - err_out = valid_out & main.err.
- if_ready = (state != SKID) & ~halt_seen & ~flush. Combinational on flush only.
- halt_seen: set at the edge where valid_out=1, instr_out[15:11]==5'b00000, hold=0 and flush=0. It stays set until reset. Once halt_seen=1, all further if_valid beats are ignored.
- Latency: a beat accepted at edge N appears on the outputs after edge N. Skid contents appear one edge after hold deasserts.
- No beat is ever lost or duplicated except those discarded by flush or drop.
- Reset mid-SKID discards both entries immediately (asynchronous).

Optional Feature:
- Macro IF_ID_STATS_EN.
- When defined: adds outputs stall_cycles[15:0], flush_count[15:0] and drop_count[15:0].
  - stall_cycles counts cycles with hold=1 and state!=EMPTY.
  - flush_count counts cycles with flush=1.
  - drop_count counts discarded if_valid beats.
  - All three saturate at 16'hFFFF and reset to 0 asynchronously.
- When undefined: the ports and counters are absent, with no other behavioural change.

Test Plan:
- Reset release, if_valid=1 with instr=16'hC123, pc=16'h0002 -> after one edge: valid_out=1, instr_out=16'hC123, pc_add2_out=16'h0002; before that edge instr_out=16'h0800.
- FULL with 16'hA001, hold=1, if_valid=1 with 16'hA002 -> state SKID, if_ready=0, instr_out stays 16'hA001. Drop hold -> instr_out=16'hA002 next edge; no beat lost.
- FULL with DROP_CNT=1, flush=1 with if_valid=1 -> next edge valid_out=0, instr_out=16'h0800. Next if_valid beat is dropped; the following beat (16'hB004) is presented.
- flush while state=SKID and dmem_stall=1 -> EMPTY after one edge; both entries discarded; drop counter=DROP_CNT.
- instr 16'h0000 in main, hold=0 -> halt_seen=1 after the edge, if_ready=0, subsequent if_valid beats ignored and valid_out drops to 0.
- if_err=1 on an accepted beat -> err_out=1 only while that instruction is valid_out. rst_n pulsed low mid-hold -> all outputs at reset values immediately.
